instruction_decoder: RTL

Decode stage of the 8-bit CME341 microprocessor. It reads the instruction word that the program sequencer's `pm_addr` fetches from synchronous program memory and drives that sequencer's jump controls (`jmp`, `jmp_nz`, `jmp_addr`, `dont_jmp`). It also drives the datapath's register-load enables, source select and ALU controls, and holds the zero flag that qualifies conditional jumps.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instruction_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CME341 decode stage: register codes, opcode classes, sequencing states.
package cpu_pkg;

  localparam logic [2:0] DST_X0 = 3'd0;
  localparam logic [2:0] DST_X1 = 3'd1;
  localparam logic [2:0] DST_Y0 = 3'd2;
  localparam logic [2:0] DST_Y1 = 3'd3;
  localparam logic [2:0] DST_O  = 3'd4;
  localparam logic [2:0] DST_M  = 3'd5;
  localparam logic [2:0] DST_I  = 3'd6;
  localparam logic [2:0] DST_DM = 3'd7;

  localparam logic [3:0] SRC_X0  = 4'h0;
  localparam logic [3:0] SRC_X1  = 4'h1;
  localparam logic [3:0] SRC_Y0  = 4'h2;
  localparam logic [3:0] SRC_Y1  = 4'h3;
  localparam logic [3:0] SRC_R   = 4'h4;
  localparam logic [3:0] SRC_M   = 4'h5;
  localparam logic [3:0] SRC_I   = 4'h6;
  localparam logic [3:0] SRC_DM  = 4'h7;
  localparam logic [3:0] SRC_IMM = 4'h8;

  typedef enum logic [2:0] {LDI, MOV, ALU, JMP, JNZ} op_class_t;

  typedef enum logic {PRIME, RUN} state_t;

  function automatic op_class_t classify(input logic [7:0] word);
    if (!word[7])                return LDI;
    else if (!word[6])           return MOV;
    else if (!word[5])           return ALU;
    else if (!word[4])           return JMP;
    else                         return JNZ;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Decode stage: combinational instruction decode, zero flag for conditional jumps,
// and a one-cycle PRIME window that masks the stale program-memory word after reset.
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic       x0_ld,
  output logic       x1_ld,
  output logic       y0_ld,
  output logic       y1_ld,
  output logic       o_reg_ld,
  output logic       m_ld,
  output logic       i_ld,
  output logic       dm_wr,
  output logic       r_ld,
  output logic [3:0] source_sel,
  output logic [3:0] imm,
  output logic [2:0] alu_func,
  output logic       x_sel,
  output logic       y_sel,
  output logic [7:0] ir
);

  state_t    state, state_next;
  op_class_t op;
  logic      active;
  logic      ld_en;
  logic [2:0] dst;
  logic      z;

  assign op       = classify(pm_data);
  // Reset is also applied combinationally so nothing leaks out while it is held.
  assign active   = sync_reset_n && (state == RUN);
  assign imm      = pm_data[3:0];
  assign dont_jmp = z;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state <= PRIME;
      z     <= 1'b0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        ir <= pm_data;
        if (op == ALU) z <= alu_zero;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PRIME: state_next = RUN;
      RUN:   state_next = RUN;
    endcase
  end

  always_comb begin
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    jmp_addr   = '0;
    r_ld       = 1'b0;
    source_sel = '0;
    alu_func   = '0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    ld_en      = 1'b0;
    dst        = '0;
    if (active) begin
      unique case (op)
        LDI: begin
          ld_en      = 1'b1;
          dst        = pm_data[6:4];
          source_sel = SRC_IMM;
        end
        MOV: begin
          if (pm_data[5:3] != pm_data[2:0]) begin
            ld_en      = 1'b1;
            dst        = pm_data[5:3];
            source_sel = {1'b0, pm_data[2:0]};
          end
        end
        ALU: begin
          r_ld     = 1'b1;
          alu_func = pm_data[4:2];
          x_sel    = pm_data[1];
          y_sel    = pm_data[0];
        end
        JMP: begin
          jmp      = 1'b1;
          jmp_addr = pm_data[3:0];
        end
        JNZ: begin
          jmp_nz   = 1'b1;
          jmp_addr = pm_data[3:0];
        end
      endcase
    end
  end

  always_comb begin
    x0_ld    = 1'b0;
    x1_ld    = 1'b0;
    y0_ld    = 1'b0;
    y1_ld    = 1'b0;
    o_reg_ld = 1'b0;
    m_ld     = 1'b0;
    i_ld     = 1'b0;
    dm_wr    = 1'b0;
    if (ld_en) begin
      unique case (dst)
        DST_X0: x0_ld    = 1'b1;
        DST_X1: x1_ld    = 1'b1;
        DST_Y0: y0_ld    = 1'b1;
        DST_Y1: y1_ld    = 1'b1;
        DST_O:  o_reg_ld = 1'b1;
        DST_M:  m_ld     = 1'b1;
        DST_I:  i_ld     = 1'b1;
        DST_DM: dm_wr    = 1'b1;
      endcase
    end
  end

endmodule
